// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the BCD converter scheduler.
package bcd_sched_pkg;

  typedef enum logic [2:0] {
    S_ARB       = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_STORE     = 3'd4
  } state_e;

  localparam logic [31:0] BCD_MAX_BIN = 32'd99_999_999;
  localparam logic [31:0] BCD_SAT     = 32'h9999_9999;

  // Eight BCD digits cannot represent anything above BCD_MAX_BIN.
  function automatic logic bcd_overflow(input logic [31:0] bin);
    return bin > BCD_MAX_BIN;
  endfunction

endpackage

// File: rtl/bcd_conv_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request after ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             grant_valid,
  output logic [IW-1:0]    grant_idx
);

  logic [IW-1:0]        w_start;
  logic [2*N_REQ-1:0]   w_dbl;
  logic [N_REQ-1:0]     w_rot;
  logic [IW-1:0]        w_off;
  logic [IW:0]          w_sum;
  logic [IW:0]          w_wrap;

  // Rotate so that bit 0 of w_rot is the requester right after ptr.
  assign w_start = (ptr == IW'(N_REQ - 1)) ? '0 : ptr + 1'b1;
  assign w_dbl   = {req, req};
  assign w_rot   = N_REQ'(w_dbl >> w_start);

  always_comb begin
    w_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IW'(i);
    end
  end

  assign w_sum       = {1'b0, w_start} + {1'b0, w_off};
  assign w_wrap      = w_sum - (IW + 1)'(N_REQ);
  assign grant_valid = |req;
  assign grant_idx   = (w_sum >= (IW + 1)'(N_REQ)) ? w_wrap[IW-1:0] : w_sum[IW-1:0];

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Shares one double-dabble converter among N_REQ requesters with
// round-robin grant, BCD saturation on overflow and a hang watchdog.
module bcd_conv_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 128,
  localparam int IW            = $clog2(N_REQ),
  localparam int WDW           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [32*N_REQ-1:0]   value,
  output logic [N_REQ-1:0]      done,
  output logic [31:0]           result,
  output logic                  ovf,
  output logic                  err,
  output logic [IW-1:0]         grant_id,
  output logic                  busy,
  output logic                  conv_trigger,
  output logic [31:0]           conv_in,
  input  logic                  conv_idle,
  input  logic [31:0]           conv_bcd
);

  state_e                  r_state;
  logic [IW-1:0]           r_ptr;
  logic [IW-1:0]           r_gid;
  logic [31:0]             r_op;
  logic                    r_ovf;
  logic [31:0]             r_res;
  logic                    r_ovf_o;
  logic                    r_err;
  logic [WDW-1:0]          r_wd;

  logic [N_REQ-1:0][31:0]  w_vals;
  logic                    w_gv;
  logic [IW-1:0]           w_gidx;
  logic                    w_timeout;

  assign w_vals = value;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req         (req),
    .ptr         (r_ptr),
    .grant_valid (w_gv),
    .grant_idx   (w_gidx)
  );

  // Counter value k means this is the (k+1)-th cycle spent waiting.
  assign w_timeout = (r_wd == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_ARB;
      r_ptr   <= IW'(N_REQ - 1);
      r_gid   <= '0;
      r_op    <= '0;
      r_ovf   <= 1'b0;
      r_res   <= '0;
      r_ovf_o <= 1'b0;
      r_err   <= 1'b0;
      r_wd    <= '0;
    end else begin
      case (r_state)
        S_ARB: begin
          if (w_gv) begin
            r_op    <= w_vals[w_gidx];
            r_ovf   <= bcd_overflow(w_vals[w_gidx]);
            r_ptr   <= w_gidx;
            r_gid   <= w_gidx;
            r_wd    <= '0;
            r_state <= S_START;
          end
        end
        S_START, S_WAIT_BUSY, S_WAIT_DONE: begin
          r_wd <= r_wd + 1'b1;
          // A completion seen in the same cycle as expiry wins over the abort.
          if (r_state == S_WAIT_DONE && conv_idle) begin
            r_res   <= r_ovf ? BCD_SAT : conv_bcd;
            r_ovf_o <= r_ovf;
            r_err   <= 1'b0;
            r_state <= S_STORE;
          end else if (w_timeout) begin
            r_res   <= '0;
            r_ovf_o <= 1'b0;
            r_err   <= 1'b1;
            r_state <= S_STORE;
          end else if (r_state == S_START && conv_idle) begin
            r_state <= S_WAIT_BUSY;
          end else if (r_state == S_WAIT_BUSY && !conv_idle) begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_STORE: r_state <= S_ARB;
        default: r_state <= S_ARB;
      endcase
    end
  end

  always_comb begin
    done = '0;
    for (int i = 0; i < N_REQ; i++) begin
      done[i] = (r_state == S_STORE) && (r_gid == IW'(i));
    end
  end

  assign result       = r_res;
  assign ovf          = r_ovf_o;
  assign err          = r_err;
  assign grant_id     = r_gid;
  assign busy         = (r_state != S_ARB);
  assign conv_trigger = (r_state == S_START) && conv_idle && !w_timeout;
  assign conv_in      = r_op;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Bench: behavioural converter (with hang mode), directed tables and a
// randomized round-robin scoreboard run.
module tb_bcd_conv_scheduler;

  localparam int N   = 4;
  localparam int TO  = 128;
  localparam int CONV_CYC = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req = '0;
  logic [32*N-1:0]   value = '0;
  logic [N-1:0]      done;
  logic [31:0]       result;
  logic              ovf, err, busy, conv_trigger;
  logic [1:0]        grant_id;
  logic [31:0]       conv_in;
  logic              conv_idle;
  logic [31:0]       conv_bcd;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_conv_scheduler #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (rst),
    .req          (req),
    .value        (value),
    .done         (done),
    .result       (result),
    .ovf          (ovf),
    .err          (err),
    .grant_id     (grant_id),
    .busy         (busy),
    .conv_trigger (conv_trigger),
    .conv_in      (conv_in),
    .conv_idle    (conv_idle),
    .conv_bcd     (conv_bcd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] to_bcd(input logic [31:0] b);
    logic [31:0] r;
    longint unsigned v;
    r = '0;
    v = longint'(b);
    for (int d = 0; d < 8; d++) begin
      r[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_res(input logic [31:0] b);
    return (b > 32'd99_999_999) ? 32'h9999_9999 : to_bcd(b);
  endfunction

  // Converter model: samples conv_in MSB-first over the first 32 busy
  // cycles, so any change on conv_in mid-conversion corrupts the result.
  logic        hang = 1'b0;
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_sh = '0;
  logic [31:0] m_bcd = '0;
  int          trig_cnt = 0;

  assign conv_idle = !m_busy;
  assign conv_bcd  = m_bcd;

  always @(posedge clk) begin
    if (conv_trigger) trig_cnt <= trig_cnt + 1;
    if (rst) begin
      m_busy <= 1'b0;
      m_bcd  <= '0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (conv_trigger && !hang) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_sh   <= '0;
      end
    end else begin
      if (m_cnt < 32) m_sh <= {m_sh[30:0], conv_in[31-m_cnt]};
      m_cnt <= m_cnt + 1;
      if (m_cnt == CONV_CYC - 1) begin
        m_busy <= 1'b0;
        m_bcd  <= to_bcd(m_sh);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_done(output int idx);
    idx = -1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done != '0) begin
        for (int i = 0; i < N; i++) if (done[i]) idx = i;
        chk("done_onehot", 32'($countones(done)), 32'd1);
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL done_timeout: no done pulse within 3000 cycles");
  endtask

  task automatic wait_busy();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL busy_timeout: busy never rose");
  endtask

  task automatic drive_req(input int i, input logic [31:0] v);
    @(posedge clk); #1;
    value[32*i +: 32] = v;
    req[i] = 1'b1;
  endtask

  task automatic drop_req(input int i);
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  typedef struct {
    int          idx;
    logic [31:0] val;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  vec_t singles[4];
  vec_t quad[4];

  initial begin
    int idx, t0, cnt, ndone, ptr_m, g_q[$];
    logic [31:0] v_q[$];
    logic [N-1:0] drop;

    singles[0] = '{0, 32'd12_345_678,  32'h1234_5678, 1'b0};
    singles[1] = '{1, 32'd100_000_000, 32'h9999_9999, 1'b1};
    singles[2] = '{2, 32'hFFFF_FFFF,   32'h9999_9999, 1'b1};
    singles[3] = '{3, 32'd90_210,      32'h0009_0210, 1'b0};
    quad[0]    = '{0, 32'd0,           32'h0000_0000, 1'b0};
    quad[1]    = '{1, 32'd7,           32'h0000_0007, 1'b0};
    quad[2]    = '{2, 32'd99_999_999,  32'h9999_9999, 1'b0};
    quad[3]    = '{3, 32'd4_095,       32'h0000_4095, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done",     32'(done), 32'd0);
    chk("rst_result",   result, 32'd0);
    chk("rst_flags",    {28'd0, ovf, err, busy, conv_trigger}, 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_conv_in",  conv_in, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 4; k++) begin
      t0 = trig_cnt;
      drive_req(singles[k].idx, singles[k].val);
      wait_done(idx);
      chk("single_idx",    idx, singles[k].idx);
      chk("single_result", result, singles[k].res);
      chk("single_ovf",    32'(ovf), 32'(singles[k].ovf));
      chk("single_err",    32'(err), 32'd0);
      drop_req(singles[k].idx);
      chk("single_trig_once", trig_cnt - t0, 32'd1);
    end

    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) value[32*quad[k].idx +: 32] = quad[k].val;
    req = 4'hF;
    for (int k = 0; k < 4; k++) begin
      wait_done(idx);
      chk("quad_order",  idx, quad[k].idx);
      chk("quad_result", result, quad[k].res);
      chk("quad_ovf",    32'(ovf), 32'(quad[k].ovf));
      drop_req(quad[k].idx);
    end

    @(posedge clk); #1;
    value[31:0]  = 32'd5;
    value[63:32] = 32'd6;
    req[1:0] = 2'b11;
    wait_busy();
    chk("fair_first_grant", 32'(grant_id), 32'd0);
    @(posedge clk); #1;
    value[31:0] = 32'd999;
    begin
      int          f_idx[4] = '{0, 1, 0, 1};
      logic [31:0] f_res[4] = '{32'h5, 32'h6, 32'h999, 32'h6};
      for (int k = 0; k < 4; k++) begin
        wait_done(idx);
        chk("fair_order",  idx, f_idx[k]);
        chk("fair_result", result, f_res[k]);
      end
    end
    @(posedge clk); #1;
    req = '0;

    hang = 1'b1;
    drive_req(2, 32'd77);
    cnt = 0;
    idx = -1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (done != '0) begin idx = c; break; end
      if (busy) cnt++;
    end
    chk("wd_seen_done", 32'(idx >= 0), 32'd1);
    chk("wd_cycles", cnt, TO);
    chk("wd_done",   32'(done), 32'h4);
    chk("wd_err",    32'(err), 32'd1);
    chk("wd_result", result, 32'd0);
    chk("wd_ovf",    32'(ovf), 32'd0);
    @(posedge clk); #1;
    req[2] = 1'b0;
    hang = 1'b0;
    drive_req(3, 32'd1234);
    wait_done(idx);
    chk("wd_recover_idx", idx, 3);
    chk("wd_recover_res", result, 32'h1234);
    chk("wd_recover_err", 32'(err), 32'd0);
    drop_req(3);

    drive_req(1, 32'd42);
    wait_busy();
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_done(idx);
    chk("rst_mid_idx",    idx, 1);
    chk("rst_mid_result", result, 32'h42);
    chk("rst_mid_err",    32'(err), 32'd0);
    drop_req(1);

    // Randomized run: scoreboard predicts grant order from the rotating
    // priority rule and result from the value present at grant time.
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ptr_m = N - 1;
    ndone = 0;
    drop = '0;
    for (int c = 0; c < 20000 && ndone < 30; c++) begin
      @(negedge clk);
      if (!busy && req != '0) begin
        int g;
        g = -1;
        for (int o = N; o >= 1; o--) if (req[(ptr_m + o) % N]) g = (ptr_m + o) % N;
        ptr_m = g;
        g_q.push_back(g);
        v_q.push_back(value[32*g +: 32]);
      end
      if (done != '0) begin
        int          g;
        logic [31:0] v;
        g = (g_q.size() > 0) ? g_q.pop_front() : 0;
        v = (v_q.size() > 0) ? v_q.pop_front() : 32'd0;
        chk("rnd_done",     32'(done), 32'd1 << g);
        chk("rnd_grant_id", 32'(grant_id), 32'(g));
        chk("rnd_result",   result, exp_res(v));
        chk("rnd_ovf",      32'(ovf), 32'(v > 32'd99_999_999));
        chk("rnd_err",      32'(err), 32'd0);
        drop[g] = 1'b1;
        ndone++;
      end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (drop[i]) begin
          req[i]  = 1'b0;
          drop[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0: value[32*i +: 32] = $urandom;
            1: value[32*i +: 32] = 32'd99_999_999 + 32'($urandom_range(0, 1));
            default: value[32*i +: 32] = 32'($urandom_range(0, 99_999_999));
          endcase
          req[i] = 1'b1;
        end
      end
    end
    chk("rnd_completed", ndone, 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_conv_scheduler.md
Name: bcd_conv_scheduler

Overview:
- Shares one unsigned_to_bcd double-dabble converter (32-bit in, 8-digit BCD out) between N_REQ requesters, e.g. several 7-segment display channels.
- Arbitrates round-robin, latches the granted operand, and sequences the converter's trigger/idle handshake.
- Returns the BCD result with a one-cycle done pulse to the granted requester.
- Adds an overflow check for inputs above 99_999_999 and a watchdog that recovers a hung conversion.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 128, max cycles allowed waiting on the converter before the scheduler aborts.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  level request; bit i is held by requester i until its done pulse.
- value  in  32*N_REQ  flattened operands; requester i uses bits [32*i+31:32*i].
- done  out  N_REQ  one-cycle pulse to the granted requester when result is valid.
- result  out  32  BCD result; valid in the done cycle, holds its value afterwards.
- ovf  out  1  qualifies done: operand exceeded 99_999_999.
- err  out  1  qualifies done: the watchdog expired.
- grant_id  out  $clog2(N_REQ)  index of the current or last granted requester.
- busy  out  1  high in every state except S_ARB.
- conv_trigger  out  1  to converter trigger.
- conv_in  out  32  to converter in; driven from the latched operand register.
- conv_idle  in  1  from converter idle.
- conv_bcd  in  32  from converter bcd.

Behaviour:
- Reset values: all outputs 0, state S_ARB, round-robin pointer at N_REQ-1 (requester 0 has first priority), operand register 0, watchdog 0.
- The converter shares the same reset net. Its reset is synchronous; the scheduler does not depend on that.
- S_ARB: when any req bit is set, grant the first set bit searching from pointer+1 with wrap-around.
  - Latch value[grant] into the operand register.
  - Set ovf_r = (operand > 32'd99_999_999).
  - Update pointer and grant_id, then go to S_START.
  - With no requests, stay in S_ARB; busy=0.
- S_START: wait for conv_idle=1, then assert conv_trigger for exactly one cycle and go to S_WAIT_BUSY. Trigger is never held high, so the converter cannot restart on its own.
- S_WAIT_BUSY: wait for conv_idle=0, then go to S_WAIT_DONE.
- S_WAIT_DONE: wait for conv_idle=1. At that point conv_bcd has been updated on the same edge, so go to S_STORE.
- S_STORE, one cycle:
  - result = ovf_r ? 32'h9999_9999 : conv_bcd.
  - ovf = ovf_r, err = 0, done[grant_id] = 1.
  - Return to S_ARB.
- Latency: 2 cycles (S_ARB grant, S_START trigger) + converter time (~64 cycles for 32 bits) + 1 cycle (S_STORE). The next grant can occur in the cycle after S_STORE.
- conv_in holds the latched operand for the entire conversion, because the converter samples it bit-by-bit. Changes on value or req after the grant have no effect.
- Watchdog:
  - Cleared on entering S_START; counts in S_START, S_WAIT_BUSY and S_WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES, go to S_STORE with err=1, result=0 and ovf=0. The done pulse still fires, so the requester never deadlocks.
- Simultaneous events:
  - A requester whose req drops mid-conversion still receives its done pulse.
  - A requester that keeps req high after done is eligible again, but the rotated pointer favours the others first.
  - Several requests in the same cycle: exactly one grant.
- Reset mid-operation: return to S_ARB immediately; no done pulse; the pending request is served afresh after reset.
- done is one-hot or zero; ovf and err are meaningful only while done is non-zero.

Decomposition:
- Package bcd_sched_pkg:
  - state enum {S_ARB, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_STORE};
  - BCD_MAX_BIN = 32'd99_999_999;
  - BCD_SAT = 32'h9999_9999.
- One natural sub-module: rr_arbiter. It is combinational, with inputs req and pointer and outputs grant_valid and grant_idx. It is reusable by other shared resources.
- The testbench instantiates unsigned_to_bcd as the converter. A stub converter with controllable idle is used for the watchdog tests.

Test Plan:
- Single request: req[0], value 12_345_678 -> done[0] once, result 32'h1234_5678, ovf=0, err=0, converter triggered exactly once.
- Four simultaneous requests:
  - operands 0, 7, 99_999_999, 4_095;
  - dones in order 0,1,2,3;
  - results 32'h0, 32'h7, 32'h9999_9999 with ovf=0, 32'h4095.
- Overflow: value 100_000_000 -> ovf=1, result 32'h9999_9999. Value 32'hFFFF_FFFF behaves the same.
- Fairness: req[0] and req[1] held high continuously -> grants alternate 0,1,0,1; operand changed after a grant does not alter that result.
- Watchdog: stub keeps conv_idle=1 after the trigger -> done with err=1, result=0 after exactly TIMEOUT_CYCLES; the next request is then served normally.
- Reset mid-conversion: assert reset in S_WAIT_DONE -> busy and done go 0 asynchronously. After release, the held req is converted correctly, e.g. 42 -> 32'h42.
